// File: rtl/tlul_interconnect_top.sv
// Single-master/single-slave TL-UL interconnect: one first-word-fall-through FIFO per channel.
// Optional macro TLUL_OPCODE_CHECK_EN answers unsupported A opcodes locally with an error response.

module tlul_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  // Head is zeroed while empty so idle payload outputs read as 0.
  assign head  = empty ? '0 : mem[rd_ptr];
endmodule

module tlul_interconnect_top #(
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter int SIZE_WIDTH   = 3,
  parameter int SRC_WIDTH    = 1,
  parameter int SINK_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int A_DEPTH      = 2,
  parameter int D_DEPTH      = 2
) (
  input  logic                    clk_24,
  input  logic                    reset,
  input  logic                    master_a_valid,
  output logic                    master_a_ready,
  input  logic [OPCODE_WIDTH-1:0] master_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  master_a_param,
  input  logic [SIZE_WIDTH-1:0]   master_a_size,
  input  logic [SRC_WIDTH-1:0]    master_a_source,
  input  logic [ADDR_WIDTH-1:0]   master_a_address,
  input  logic [MASK_WIDTH-1:0]   master_a_mask,
  input  logic [DATA_WIDTH-1:0]   master_a_data,
  output logic                    master_d_valid,
  input  logic                    master_d_ready,
  output logic [OPCODE_WIDTH-1:0] master_d_opcode,
  output logic [PARAM_WIDTH-1:0]  master_d_param,
  output logic [SIZE_WIDTH-1:0]   master_d_size,
  output logic [SRC_WIDTH-1:0]    master_d_source,
  output logic [SINK_WIDTH-1:0]   master_d_sink,
  output logic [DATA_WIDTH-1:0]   master_d_data,
  output logic                    master_d_error,
  output logic                    slave_a_valid,
  input  logic                    slave_a_ready,
  output logic [OPCODE_WIDTH-1:0] slave_a_opcode,
  output logic [PARAM_WIDTH-1:0]  slave_a_param,
  output logic [SIZE_WIDTH-1:0]   slave_a_size,
  output logic [SRC_WIDTH-1:0]    slave_a_source,
  output logic [ADDR_WIDTH-1:0]   slave_a_address,
  output logic [MASK_WIDTH-1:0]   slave_a_mask,
  output logic [DATA_WIDTH-1:0]   slave_a_data,
  input  logic                    slave_d_valid,
  output logic                    slave_d_ready,
  input  logic [OPCODE_WIDTH-1:0] slave_d_opcode,
  input  logic [PARAM_WIDTH-1:0]  slave_d_param,
  input  logic [SIZE_WIDTH-1:0]   slave_d_size,
  input  logic [SRC_WIDTH-1:0]    slave_d_source,
  input  logic [SINK_WIDTH-1:0]   slave_d_sink,
  input  logic [DATA_WIDTH-1:0]   slave_d_data,
  input  logic                    slave_d_error
);
  // A entry carries a "local" flag in its MSB for requests the slave must never see.
  localparam int A_PAYLOAD = OPCODE_WIDTH + PARAM_WIDTH + SIZE_WIDTH + SRC_WIDTH
                           + ADDR_WIDTH + MASK_WIDTH + DATA_WIDTH;
  localparam int A_W       = A_PAYLOAD + 1;
  localparam int D_W       = OPCODE_WIDTH + PARAM_WIDTH + SIZE_WIDTH + SRC_WIDTH
                           + SINK_WIDTH + DATA_WIDTH + 1;

  logic             ready_en;
  logic             a_bad;
  logic             inject;
  logic             a_push, a_pop, a_full, a_empty;
  logic [A_W-1:0]   a_head;
  logic [A_PAYLOAD-1:0] a_out;
  logic             d_push, d_pop, d_full, d_empty;
  logic [D_W-1:0]   d_in, d_local, d_head;

  // Holds both ready outputs low until the first edge after reset release.
  always_ff @(posedge clk_24 or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign master_a_ready = ready_en && !a_full;
  assign a_push         = master_a_valid && master_a_ready;
  assign slave_a_valid  = !a_empty && !a_head[A_W-1];
  assign a_pop          = (slave_a_valid && slave_a_ready) || inject;
  assign a_out          = slave_a_valid ? a_head[A_PAYLOAD-1:0] : '0;
  assign {slave_a_opcode, slave_a_param, slave_a_size, slave_a_source,
          slave_a_address, slave_a_mask, slave_a_data} = a_out;

  tlul_fifo #(.WIDTH(A_W), .DEPTH(A_DEPTH)) u_a_fifo (
    .clk       (clk_24),
    .rst_n     (reset),
    .push      (a_push),
    .push_data ({a_bad, master_a_opcode, master_a_param, master_a_size, master_a_source,
                 master_a_address, master_a_mask, master_a_data}),
    .pop       (a_pop),
    .head      (a_head),
    .full      (a_full),
    .empty     (a_empty)
  );

  assign slave_d_ready  = ready_en && !d_full && !inject;
  assign d_push         = (slave_d_valid && slave_d_ready) || inject;
  assign d_in           = inject ? d_local
                                 : {slave_d_opcode, slave_d_param, slave_d_size, slave_d_source,
                                    slave_d_sink, slave_d_data, slave_d_error};
  assign master_d_valid = !d_empty;
  assign d_pop          = master_d_valid && master_d_ready;
  assign {master_d_opcode, master_d_param, master_d_size, master_d_source,
          master_d_sink, master_d_data, master_d_error} = d_head;

  tlul_fifo #(.WIDTH(D_W), .DEPTH(D_DEPTH)) u_d_fifo (
    .clk       (clk_24),
    .rst_n     (reset),
    .push      (d_push),
    .push_data (d_in),
    .pop       (d_pop),
    .head      (d_head),
    .full      (d_full),
    .empty     (d_empty)
  );

`ifdef TLUL_OPCODE_CHECK_EN
  localparam int SRC_LSB  = ADDR_WIDTH + MASK_WIDTH + DATA_WIDTH;
  localparam int SIZE_LSB = SRC_LSB + SRC_WIDTH;
  localparam int OP_LSB   = SIZE_LSB + SIZE_WIDTH + PARAM_WIDTH;

  logic [7:0]              inflight;
  logic                    fwd, rsp;
  logic [OPCODE_WIDTH-1:0] head_opcode;

  assign a_bad = !((master_a_opcode == OPCODE_WIDTH'(0)) || (master_a_opcode == OPCODE_WIDTH'(1)) ||
                   (master_a_opcode == OPCODE_WIDTH'(4)));
  assign fwd   = slave_a_valid && slave_a_ready;
  assign rsp   = slave_d_valid && slave_d_ready;

  // Counts requests handed to the slave whose response has not yet entered the D FIFO.
  always_ff @(posedge clk_24 or negedge reset) begin
    if (!reset)                               inflight <= '0;
    else if (fwd && !rsp)                     inflight <= inflight + 8'd1;
    else if (!fwd && rsp && inflight != '0)   inflight <= inflight - 8'd1;
  end

  assign head_opcode = a_head[OP_LSB +: OPCODE_WIDTH];
  assign inject      = ready_en && !a_empty && a_head[A_W-1] && (inflight == '0) && !d_full;
  assign d_local     = {(head_opcode >= OPCODE_WIDTH'(4)) ? OPCODE_WIDTH'(1) : OPCODE_WIDTH'(0),
                        PARAM_WIDTH'(0), a_head[SIZE_LSB +: SIZE_WIDTH], a_head[SRC_LSB +: SRC_WIDTH],
                        SINK_WIDTH'(0), DATA_WIDTH'(0), 1'b1};
`else
  assign a_bad   = 1'b0;
  assign inject  = 1'b0;
  assign d_local = '0;
`endif
endmodule

// File: tb/tb_tlul_interconnect_top.sv
// Scoreboard bench for tlul_interconnect_top: queue-based channel model, directed plan items then random traffic.

module tb_tlul_interconnect_top;
  localparam int AD = 2;
  localparam int DD = 2;

  typedef struct packed {
    logic [2:0] opcode; logic [2:0] param; logic [2:0] size; logic source;
    logic [31:0] address; logic [3:0] mask; logic [31:0] data;
  } a_item_t;
  typedef struct packed {
    logic [2:0] opcode; logic [2:0] param; logic [2:0] size; logic source;
    logic sink; logic [31:0] data; logic error;
  } d_item_t;

  logic clk_24, reset;
  logic master_a_valid, master_a_ready, master_d_valid, master_d_ready;
  logic slave_a_valid, slave_a_ready, slave_d_valid, slave_d_ready;
  a_item_t m_a, slave_a_obs;
  d_item_t s_d, master_d_obs;
  logic [2:0] slave_a_opcode, slave_a_param, slave_a_size;
  logic slave_a_source;
  logic [31:0] slave_a_address, slave_a_data;
  logic [3:0] slave_a_mask;
  logic [2:0] master_d_opcode, master_d_param, master_d_size;
  logic master_d_source, master_d_sink, master_d_error;
  logic [31:0] master_d_data;

  assign slave_a_obs  = {slave_a_opcode, slave_a_param, slave_a_size, slave_a_source,
                         slave_a_address, slave_a_mask, slave_a_data};
  assign master_d_obs = {master_d_opcode, master_d_param, master_d_size, master_d_source,
                         master_d_sink, master_d_data, master_d_error};

  tlul_interconnect_top dut (
    .clk_24(clk_24), .reset(reset),
    .master_a_valid(master_a_valid), .master_a_ready(master_a_ready),
    .master_a_opcode(m_a.opcode), .master_a_param(m_a.param), .master_a_size(m_a.size),
    .master_a_source(m_a.source), .master_a_address(m_a.address), .master_a_mask(m_a.mask),
    .master_a_data(m_a.data),
    .master_d_valid(master_d_valid), .master_d_ready(master_d_ready),
    .master_d_opcode(master_d_opcode), .master_d_param(master_d_param), .master_d_size(master_d_size),
    .master_d_source(master_d_source), .master_d_sink(master_d_sink), .master_d_data(master_d_data),
    .master_d_error(master_d_error),
    .slave_a_valid(slave_a_valid), .slave_a_ready(slave_a_ready),
    .slave_a_opcode(slave_a_opcode), .slave_a_param(slave_a_param), .slave_a_size(slave_a_size),
    .slave_a_source(slave_a_source), .slave_a_address(slave_a_address), .slave_a_mask(slave_a_mask),
    .slave_a_data(slave_a_data),
    .slave_d_valid(slave_d_valid), .slave_d_ready(slave_d_ready),
    .slave_d_opcode(s_d.opcode), .slave_d_param(s_d.param), .slave_d_size(s_d.size),
    .slave_d_source(s_d.source), .slave_d_sink(s_d.sink), .slave_d_data(s_d.data),
    .slave_d_error(s_d.error)
  );

  initial clk_24 = 1'b0;
  always #5 clk_24 = ~clk_24;

  int n_checks = 0, n_fail = 0;
  a_item_t a_tx[$], exp_a[$];
  d_item_t d_tx[$], exp_d[$];
  int a_vld_pct = 100, s_a_rdy_pct = 100, d_vld_pct = 100, m_d_rdy_pct = 100;
  bit mon_en = 0, a_fired = 0, d_fired = 0;
  int a_fire_cnt = 0, d_fire_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic a_item_t rand_a();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[77:0];
  endfunction

  function automatic d_item_t rand_d();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[43:0];
  endfunction

  // Master A driver: holds a request until accepted, records accepted requests as expectations.
  initial forever begin
    @(posedge clk_24); #1;
    if (!reset) master_a_valid = 1'b0;
    else if (!(master_a_valid && !a_fired)) begin
      if (a_tx.size() > 0 && $urandom_range(99) < a_vld_pct) begin
        m_a = a_tx.pop_front();
        master_a_valid = 1'b1;
      end else master_a_valid = 1'b0;
    end
    a_fired = 1'b0;
    slave_a_ready  = reset && ($urandom_range(99) < s_a_rdy_pct);
    master_d_ready = reset && ($urandom_range(99) < m_d_rdy_pct);
    #6;
    if (reset && master_a_valid && master_a_ready) begin
      exp_a.push_back(m_a);
      a_fired = 1'b1;
    end
  end

  // Slave D driver.
  initial forever begin
    @(posedge clk_24); #1;
    if (!reset) slave_d_valid = 1'b0;
    else if (!(slave_d_valid && !d_fired)) begin
      if (d_tx.size() > 0 && $urandom_range(99) < d_vld_pct) begin
        s_d = d_tx.pop_front();
        slave_d_valid = 1'b1;
      end else slave_d_valid = 1'b0;
    end
    d_fired = 1'b0;
    #6;
    if (reset && slave_d_valid && slave_d_ready) begin
      exp_d.push_back(s_d);
      d_fired = 1'b1;
    end
  end

  // Monitor: occupancy-derived valid/ready, zero idle payload, in-order bit-exact delivery.
  initial forever begin
    @(negedge clk_24);
    if (mon_en) begin
      chk("a_valid", 128'(slave_a_valid), 128'(exp_a.size() != 0));
      chk("a_ready", 128'(master_a_ready), 128'(exp_a.size() < AD));
      if (!slave_a_valid) chk("a_idle_zero", 128'(slave_a_obs), 128'(0));
      else if (slave_a_ready && exp_a.size() > 0) begin
        chk("a_payload", 128'(slave_a_obs), 128'(exp_a.pop_front()));
        a_fire_cnt++;
      end
      chk("d_valid", 128'(master_d_valid), 128'(exp_d.size() != 0));
      chk("d_ready", 128'(slave_d_ready), 128'(exp_d.size() < DD));
      if (!master_d_valid) chk("d_idle_zero", 128'(master_d_obs), 128'(0));
      else if (master_d_ready && exp_d.size() > 0) begin
        chk("d_payload", 128'(master_d_obs), 128'(exp_d.pop_front()));
        d_fire_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, budget;
    reset = 1'b0; master_a_valid = 1'b0; slave_d_valid = 1'b0;
    slave_a_ready = 1'b0; master_d_ready = 1'b0; m_a = '0; s_d = '0;

    repeat (3) @(posedge clk_24);
    #2;
    chk("rst_a_ready", 128'(master_a_ready), 128'(0));
    chk("rst_d_ready", 128'(slave_d_ready), 128'(0));
    chk("rst_a_valid", 128'(slave_a_valid), 128'(0));
    chk("rst_d_valid", 128'(master_d_valid), 128'(0));
    chk("rst_payload", 128'({slave_a_obs, master_d_obs}), 128'(0));
    reset = 1'b1;
    @(posedge clk_24); #2;
    chk("rel_a_ready", 128'(master_a_ready), 128'(1));
    chk("rel_d_ready", 128'(slave_d_ready), 128'(1));
    chk("rel_a_valid", 128'(slave_a_valid), 128'(0));
    chk("rel_d_valid", 128'(master_d_valid), 128'(0));
    mon_en = 1'b1;

    // Buffering with the slave stalled, then back-to-back drain.
    s_a_rdy_pct = 0;
    a_tx.push_back('{3'd0, 3'd0, 3'd2, 1'b0, 32'h0000_1000, 4'hF, 32'hA5A5_A5A5});
    a_tx.push_back('{3'd4, 3'd0, 3'd2, 1'b1, 32'h0000_2000, 4'hF, 32'h0});
    budget = 0;
    while (exp_a.size() < 2 && budget < 20) begin @(posedge clk_24); #2; budget++; end
    chk("buf_accepted", 128'(exp_a.size()), 128'(2));
    @(negedge clk_24); #1;
    chk("buf_a_ready_low", 128'(master_a_ready), 128'(0));
    @(posedge clk_24); #2;
    s_a_rdy_pct = 100;
    @(posedge clk_24); #2;
    start = a_fire_cnt;
    @(negedge clk_24); #1;
    @(negedge clk_24); #1;
    chk("buf_back_to_back", 128'(a_fire_cnt - start), 128'(2));

    // Response path and error propagation.
    start = d_fire_cnt;
    d_tx.push_back('{3'd1, 3'd0, 3'd2, 1'b1, 1'b0, 32'h1234_5678, 1'b0});
    d_tx.push_back('{3'd0, 3'd0, 3'd2, 1'b0, 1'b1, 32'h0, 1'b1});
    budget = 0;
    while ((d_tx.size() != 0 || exp_d.size() != 0 || slave_d_valid) && budget < 30) begin
      @(posedge clk_24); #2; budget++;
    end
    chk("resp_delivered", 128'(d_fire_cnt - start), 128'(2));

    // D backpressure: third response must stall.
    m_d_rdy_pct = 0;
    repeat (3) d_tx.push_back(rand_d());
    budget = 0;
    while (exp_d.size() < 2 && budget < 30) begin @(posedge clk_24); #2; budget++; end
    @(negedge clk_24); #1;
    chk("dbp_slave_ready_low", 128'(slave_d_ready), 128'(0));
    chk("dbp_third_pending", 128'(slave_d_valid), 128'(1));
    @(posedge clk_24); #2;
    m_d_rdy_pct = 100;
    start = d_fire_cnt;
    budget = 0;
    while ((exp_d.size() != 0 || slave_d_valid) && budget < 30) begin @(posedge clk_24); #2; budget++; end
    chk("dbp_delivered", 128'(d_fire_cnt - start), 128'(3));

    // Mid-transfer reset discards buffered requests.
    s_a_rdy_pct = 0;
    a_tx.push_back(rand_a());
    a_tx.push_back(rand_a());
    budget = 0;
    while (exp_a.size() < 2 && budget < 20) begin @(posedge clk_24); #2; budget++; end
    chk("mid_buffered", 128'(exp_a.size()), 128'(2));
    mon_en = 1'b0;
    @(posedge clk_24); #2;
    reset = 1'b0;
    #1;
    chk("mid_a_valid_now", 128'(slave_a_valid), 128'(0));
    chk("mid_a_ready_now", 128'(master_a_ready), 128'(0));
    a_tx.delete(); exp_a.delete(); d_tx.delete(); exp_d.delete();
    repeat (2) @(posedge clk_24);
    #2;
    reset = 1'b1;
    s_a_rdy_pct = 100;
    @(posedge clk_24); #2;
    chk("mid_after_a_valid", 128'(slave_a_valid), 128'(0));
    chk("mid_after_a_ready", 128'(master_a_ready), 128'(1));
    mon_en = 1'b1;

    // Random traffic with varying handshake pressure.
    for (int r = 0; r < 8; r++) begin
      a_vld_pct   = $urandom_range(100, 20);
      s_a_rdy_pct = $urandom_range(100, 20);
      d_vld_pct   = $urandom_range(100, 20);
      m_d_rdy_pct = $urandom_range(100, 20);
      for (int i = 0; i < 40; i++) begin
        a_tx.push_back(rand_a());
        d_tx.push_back(rand_d());
      end
      repeat (60) @(posedge clk_24);
      #2;
    end
    a_vld_pct = 100; s_a_rdy_pct = 100; d_vld_pct = 100; m_d_rdy_pct = 100;
    budget = 0;
    while ((a_tx.size() != 0 || exp_a.size() != 0 || master_a_valid ||
            d_tx.size() != 0 || exp_d.size() != 0 || slave_d_valid) && budget < 3000) begin
      @(posedge clk_24); #2; budget++;
    end
    chk("drain_complete", 128'(budget < 3000), 128'(1));
    @(negedge clk_24); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
